// File: rtl/amo_unit.sv
// RV64A atomic responder: AMO read-modify-write, LR/SC with one reservation, old value returned.
// Optional macro WIV_AMO_MINMAX_EN enables AMOMIN/MAX/MINU/MAXU; otherwise they report an error.
module amo_unit #(
  parameter int unsigned RSV_GRAN_LOG2 = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [4:0]  req_funct5_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_sel_o,
  input  logic        mem_ack_i,
  input  logic [63:0] mem_rdata_i,
  input  logic        snoop_st_i,
  input  logic [63:0] snoop_addr_i
);

  localparam int unsigned TagW = 64 - RSV_GRAN_LOG2;

  localparam logic [4:0] F5Add  = 5'h00;
  localparam logic [4:0] F5Swap = 5'h01;
  localparam logic [4:0] F5Lr   = 5'h02;
  localparam logic [4:0] F5Sc   = 5'h03;
  localparam logic [4:0] F5Xor  = 5'h04;
  localparam logic [4:0] F5Or   = 5'h08;
  localparam logic [4:0] F5And  = 5'h0C;
`ifdef WIV_AMO_MINMAX_EN
  localparam logic [4:0] F5Min  = 5'h10;
  localparam logic [4:0] F5Max  = 5'h14;
  localparam logic [4:0] F5Minu = 5'h18;
  localparam logic [4:0] F5Maxu = 5'h1C;
`endif

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e           state_q;
  logic [4:0]       funct5_q;
  logic             word_q;
  logic [63:0]      addr_q, data_q;
  logic             rsv_valid_q;
  logic [TagW-1:0]  rsv_tag_q;
  logic             mem_req_q, mem_we_q;
  logic [63:0]      mem_addr_q, mem_wdata_q;
  logic [7:0]       mem_sel_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [63:0]      rsp_data_q;

  logic             req_word, f3_ok, misaligned, f5_ok, req_err, sc_hit;
  logic [7:0]       req_sel;
  logic [63:0]      sc_wdata;
  logic [31:0]      lane;
  logic [63:0]      old_val, opb, amo_res, amo_wdata;
  logic             snoop_kill, lr_blocked;
`ifdef WIV_AMO_MINMAX_EN
  logic             lt_s, lt_u;
`endif
  logic             unused_bits;

  assign unused_bits = ^{snoop_addr_i[RSV_GRAN_LOG2-1:0], addr_q[1:0]};

  always_comb begin
    req_word   = (req_funct3_i == 3'h2);
    f3_ok      = req_word || (req_funct3_i == 3'h3);
    misaligned = req_word ? (req_addr_i[1:0] != 2'b00) : (req_addr_i[2:0] != 3'b000);
    f5_ok      = 1'b0;
    case (req_funct5_i)
      F5Add, F5Swap, F5Lr, F5Sc, F5Xor, F5Or, F5And: f5_ok = 1'b1;
`ifdef WIV_AMO_MINMAX_EN
      F5Min, F5Max, F5Minu, F5Maxu:                  f5_ok = 1'b1;
`endif
      default:                                       f5_ok = 1'b0;
    endcase
    req_err  = !f3_ok || misaligned || !f5_ok;
    sc_hit   = rsv_valid_q && (rsv_tag_q == req_addr_i[63:RSV_GRAN_LOG2]);
    req_sel  = req_word ? (req_addr_i[2] ? 8'hF0 : 8'h0F) : 8'hFF;
    sc_wdata = req_word ? {2{req_data_i[31:0]}} : req_data_i;
  end

  // Word ops sign-extend both operands so one 64-bit datapath serves W and D alike.
  always_comb begin
    lane    = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    old_val = word_q ? {{32{lane[31]}}, lane} : mem_rdata_i;
    opb     = word_q ? {{32{data_q[31]}}, data_q[31:0]} : data_q;
`ifdef WIV_AMO_MINMAX_EN
    lt_s    = $signed(old_val) < $signed(opb);
    lt_u    = old_val < opb;
`endif
    case (funct5_q)
      F5Add:   amo_res = old_val + opb;
      F5Xor:   amo_res = old_val ^ opb;
      F5Or:    amo_res = old_val | opb;
      F5And:   amo_res = old_val & opb;
`ifdef WIV_AMO_MINMAX_EN
      F5Min:   amo_res = lt_s ? old_val : opb;
      F5Max:   amo_res = lt_s ? opb : old_val;
      F5Minu:  amo_res = lt_u ? old_val : opb;
      F5Maxu:  amo_res = lt_u ? opb : old_val;
`endif
      default: amo_res = opb;
    endcase
    amo_wdata  = word_q ? {2{amo_res[31:0]}} : amo_res;
    snoop_kill = snoop_st_i && rsv_valid_q &&
                 (snoop_addr_i[63:RSV_GRAN_LOG2] == rsv_tag_q);
    lr_blocked = snoop_st_i && (snoop_addr_i[63:RSV_GRAN_LOG2] == addr_q[63:RSV_GRAN_LOG2]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      funct5_q    <= 5'h0;
      word_q      <= 1'b0;
      addr_q      <= 64'h0;
      data_q      <= 64'h0;
      rsv_valid_q <= 1'b0;
      rsv_tag_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'h0;
      mem_wdata_q <= 64'h0;
      mem_sel_q   <= 8'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 64'h0;
    end else begin
      if (snoop_kill) rsv_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            funct5_q   <= req_funct5_i;
            word_q     <= req_word;
            addr_q     <= req_addr_i;
            data_q     <= req_data_i;
            mem_addr_q <= {req_addr_i[63:3], 3'b000};
            mem_sel_q  <= req_sel;
            if (req_funct5_i == F5Sc) rsv_valid_q <= 1'b0;
            if (req_err) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 64'h0;
              state_q     <= StResp;
            end else if (req_funct5_i == F5Sc) begin
              if (sc_hit) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= sc_wdata;
                rsp_data_q  <= 64'h0;
                state_q     <= StWrite;
              end else begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= 64'h1;
                state_q     <= StResp;
              end
            end else begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state_q   <= StRead;
            end
          end
        end
        StRead: begin
          if (mem_ack_i) begin
            rsp_data_q <= old_val;
            if (funct5_q == F5Lr) begin
              mem_req_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsv_valid_q <= !lr_blocked;
              rsv_tag_q   <= addr_q[63:RSV_GRAN_LOG2];
              state_q     <= StResp;
            end else begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= amo_wdata;
              state_q     <= StWrite;
            end
          end
        end
        StWrite: begin
          if (mem_ack_i) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 64'h0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_sel_o   = mem_sel_q;

endmodule

// File: tb/tb_amo_unit.sv
// Scoreboard bench for amo_unit: directed vectors, memory model with ack delay, stability monitors.
module tb_amo_unit;

  localparam logic [4:0] F_ADD = 5'h00, F_SWAP = 5'h01, F_LR = 5'h02, F_SC = 5'h03;
  localparam logic [4:0] F_XOR = 5'h04, F_AND = 5'h0C, F_MIN = 5'h10, F_MAXU = 5'h1C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_funct5 = 5'h0;
  logic [2:0]  req_funct3 = 3'h0;
  logic [63:0] req_addr = 64'h0, req_data = 64'h0;
  logic        rsp_valid, rsp_err;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_data;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_sel;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = 64'h0;
  logic        snoop_st = 1'b0;
  logic [63:0] snoop_addr = 64'h0;

  amo_unit #(.RSV_GRAN_LOG2(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_funct5_i(req_funct5), .req_funct3_i(req_funct3),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_sel_o(mem_sel),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .snoop_st_i(snoop_st), .snoop_addr_i(snoop_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;
  exp_t sb[$];

  // Response monitor: latency on first sight, data/err on handshake, stability while stalled.
  bit          seen = 0;
  logic        pv_valid = 0, pv_ready = 0, pv_err = 0;
  logic [63:0] pv_data = 0;
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        if (!seen) begin
          seen = 1;
          chk({sb[0].name, ".lat"}, 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        end
        if (rsp_ready) begin
          chk({sb[0].name, ".data"}, rsp_data, sb[0].data);
          chk({sb[0].name, ".err"}, 64'(rsp_err), 64'(sb[0].err));
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
    if (rst_n && pv_valid && !pv_ready) begin
      chk("rsp_hold.valid", 64'(rsp_valid), 64'd1);
      chk("rsp_hold.data", rsp_data, pv_data);
      chk("rsp_hold.err", 64'(rsp_err), 64'(pv_err));
    end
    pv_valid = rsp_valid; pv_ready = rsp_ready; pv_data = rsp_data; pv_err = rsp_err;
  end

  // Memory model: ack after ack_delay wait cycles, byte-strobed writes, activity log.
  logic [63:0] mem_model [logic [63:0]];
  int          ack_delay = 0, wait_cnt = 0, wr_cnt = 0, req_cycles = 0;
  logic [63:0] last_wdata = 0, last_waddr = 0;
  logic [7:0]  last_sel = 0;
  logic        pm_req = 0, pm_ack = 0, pm_we = 0;
  logic [63:0] pm_addr = 0, pm_wdata = 0;
  logic [7:0]  pm_sel = 0;
  always @(negedge clk) begin
    logic [63:0] m;
    if (rst_n && mem_req) begin
      req_cycles++;
      if (pm_req && !pm_ack) begin
        chk("bus_hold.addr", mem_addr, pm_addr);
        chk("bus_hold.we", 64'(mem_we), 64'(pm_we));
        chk("bus_hold.wdata", mem_wdata, pm_wdata);
        chk("bus_hold.sel", 64'(mem_sel), 64'(pm_sel));
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        m = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 64'h0;
        mem_rdata = m;
        if (mem_we) begin
          for (int b = 0; b < 8; b++) if (mem_sel[b]) m[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_model[mem_addr] = m;
          wr_cnt++;
          last_wdata = mem_wdata; last_sel = mem_sel; last_waddr = mem_addr;
        end
        wait_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end
    pm_req = rst_n && mem_req; pm_ack = mem_ack; pm_we = mem_we;
    pm_addr = mem_addr; pm_wdata = mem_wdata; pm_sel = mem_sel;
  end

  task automatic issue(input string name, input logic [4:0] f5, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] data,
                       input logic [63:0] edata, input logic eerr, input int elat);
    int n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk({name, ".ready_timeout"}, 64'(req_ready), 64'd1);
      return;
    end
    req_funct5 = f5; req_funct3 = f3; req_addr = addr; req_data = data;
    req_valid = 1'b1;
    sb.push_back('{edata, eerr, elat, cyc, name});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk({name, ".rsp_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  int w0, r0;
  task automatic snap();
    w0 = wr_cnt; r0 = req_cycles;
  endtask

  task automatic snoop(input logic [63:0] a);
    snoop_st = 1'b1; snoop_addr = a;
    @(posedge clk); #1;
    snoop_st = 1'b0;
  endtask

  initial begin
    int n;
    mem_model[64'h1000] = 64'h7FFF_FFFF_FFFF_FFFF;
    mem_model[64'h2000] = 64'h1111_2222_3333_4444;
    mem_model[64'h4000] = 64'h0F0F_0F0F_0F0F_0F0F;
    mem_model[64'h5000] = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.req_ready", 64'(req_ready), 64'd1);
    chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset.mem_req", 64'(mem_req), 64'd0);
    chk("reset.rsp_data", rsp_data, 64'd0);
    rst_n = 1'b1;

    snap();
    issue("add_d", F_ADD, 3'h3, 64'h1000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3);
    wait_done("add_d");
    chk("add_d.writes", 64'(wr_cnt - w0), 64'd1);
    chk("add_d.wdata", last_wdata, 64'h8000_0000_0000_0000);
    chk("add_d.sel", 64'(last_sel), 64'hFF);
    chk("add_d.waddr", last_waddr, 64'h1000);

    mem_model[64'h1000] = 64'h8000_0000_1234_5678;
    snap();
`ifdef WIV_AMO_MINMAX_EN
    issue("min_w", F_MIN, 3'h2, 64'h1004, 64'h5, 64'hFFFF_FFFF_8000_0000, 1'b0, 3);
    wait_done("min_w");
    chk("min_w.sel", 64'(last_sel), 64'hF0);
    chk("min_w.wdata_hi", 64'(last_wdata[63:32]), 64'h8000_0000);
    snap();
    issue("maxu_w", F_MAXU, 3'h2, 64'h1000, 64'hFFFF_FFFF, 64'h1234_5678, 1'b0, 3);
    wait_done("maxu_w");
    chk("maxu_w.sel", 64'(last_sel), 64'h0F);
    chk("maxu_w.mem", mem_model[64'h1000], 64'h8000_0000_FFFF_FFFF);
`else
    issue("min_w", F_MIN, 3'h2, 64'h1004, 64'h5, 64'h0, 1'b1, 1);
    wait_done("min_w");
    chk("min_w.no_req", 64'(req_cycles - r0), 64'd0);
    issue("maxu_w", F_MAXU, 3'h2, 64'h1000, 64'hFFFF_FFFF, 64'h0, 1'b1, 1);
    wait_done("maxu_w");
    chk("maxu_w.no_req", 64'(req_cycles - r0), 64'd0);
`endif

    issue("lr_d", F_LR, 3'h3, 64'h2000, 64'h0, 64'h1111_2222_3333_4444, 1'b0, 2);
    wait_done("lr_d");
    snap();
    issue("sc_ok", F_SC, 3'h3, 64'h2000, 64'hAB, 64'h0, 1'b0, 2);
    wait_done("sc_ok");
    chk("sc_ok.writes", 64'(wr_cnt - w0), 64'd1);
    chk("sc_ok.mem", mem_model[64'h2000], 64'hAB);
    snap();
    issue("sc_again", F_SC, 3'h3, 64'h2000, 64'hCC, 64'h1, 1'b0, 1);
    wait_done("sc_again");
    chk("sc_again.no_req", 64'(req_cycles - r0), 64'd0);

    issue("lr_snp", F_LR, 3'h3, 64'h2000, 64'h0, 64'hAB, 1'b0, 2);
    wait_done("lr_snp");
    snoop(64'h2004);
    snap();
    issue("sc_snp", F_SC, 3'h3, 64'h2000, 64'hEE, 64'h1, 1'b0, 1);
    wait_done("sc_snp");
    chk("sc_snp.no_req", 64'(req_cycles - r0), 64'd0);

    issue("lr_ack_snp", F_LR, 3'h3, 64'h2000, 64'h0, 64'hAB, 1'b0, 2);
    snoop(64'h2004);
    wait_done("lr_ack_snp");
    snap();
    issue("sc_ack_snp", F_SC, 3'h3, 64'h2000, 64'hEE, 64'h1, 1'b0, 1);
    wait_done("sc_ack_snp");
    chk("sc_ack_snp.no_req", 64'(req_cycles - r0), 64'd0);

    issue("lr_far", F_LR, 3'h3, 64'h2000, 64'h0, 64'hAB, 1'b0, 2);
    wait_done("lr_far");
    snoop(64'h2008);
    issue("sc_far", F_SC, 3'h3, 64'h2000, 64'hCD, 64'h0, 1'b0, 2);
    wait_done("sc_far");
    chk("sc_far.mem", mem_model[64'h2000], 64'hCD);

    snap();
    issue("swap_mis", F_SWAP, 3'h2, 64'h3002, 64'h1, 64'h0, 1'b1, 1);
    wait_done("swap_mis");
    issue("d_mis", F_ADD, 3'h3, 64'h3004, 64'h1, 64'h0, 1'b1, 1);
    wait_done("d_mis");
    issue("bad_f3", F_ADD, 3'h0, 64'h3000, 64'h1, 64'h0, 1'b1, 1);
    wait_done("bad_f3");
    issue("bad_f5", 5'h05, 3'h3, 64'h3000, 64'h1, 64'h0, 1'b1, 1);
    wait_done("bad_f5");
    chk("err.no_req", 64'(req_cycles - r0), 64'd0);

    ack_delay = 3;
    rsp_ready = 1'b0;
    issue("xor_d", F_XOR, 3'h3, 64'h4000, 64'hFFFF_0000_FFFF_0000,
          64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 9);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_done("xor_d");
    chk("xor_d.mem", mem_model[64'h4000], 64'hF0F0_0F0F_F0F0_0F0F);

    ack_delay = 0;
    issue("lr_rst", F_LR, 3'h3, 64'h2000, 64'h0, 64'hCD, 1'b0, 2);
    wait_done("lr_rst");
    ack_delay = 10;
    snap();
    issue("and_rst", F_AND, 3'h3, 64'h5000, 64'h1, 64'h0, 1'b0, 0);
    n = 0;
    while (!(mem_req && mem_we) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("and_rst.in_write", 64'(mem_req && mem_we), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    seen = 0;
    chk("rst_mid.mem_req", 64'(mem_req), 64'd0);
    chk("rst_mid.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid.req_ready", 64'(req_ready), 64'd1);
    chk("rst_mid.writes", 64'(wr_cnt - w0), 64'd0);
    ack_delay = 0;
    snap();
    issue("sc_after_rst", F_SC, 3'h3, 64'h2000, 64'h55, 64'h1, 1'b0, 1);
    wait_done("sc_after_rst");
    chk("sc_after_rst.no_req", 64'(req_cycles - r0), 64'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
